arb4_grant_ctrl: RTL and testbench

Four-requester arbiter that shares one downstream resource (bus, shared register port, encoder datapath) among requesters `req[3:0]`. It resolves contention with either fixed priority (req[3] highest, req[0] lowest) or rotating round-robin priority. It registers a one-hot grant plus a 2-bit encoded winner index, and holds each grant until the owner releases or a hold limit expires. It sits between the request sources and the shared resource's select/enable inputs.

---
 rtl/arb4_grant_ctrl.sv | 116 +++++++++++
 tb/tb_arb4_grant_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/arb4_grant_ctrl.sv
// Four-requester arbiter, fixed or round-robin priority, registered one-hot grant.
// Latency: request to grant 1 cycle, release 1 cycle, one idle cycle between grants.
// Backpressure: owner holds by keeping its request high, up to MAX_HOLD cycles; no preemption.
module arb4_grant_ctrl #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rr_en_i,
  input  logic [3:0] req_i,
  output logic [3:0] gnt_o,
  output logic [1:0] gnt_id_o,
  output logic       gnt_vld_o,
  output logic       expired_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       gnt_id_q, gnt_id_d;
  logic [1:0]       last_q, last_d;
  logic             expired_q, expired_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [1:0] scan_base;
  logic [1:0] scan_idx;
  logic [1:0] win_idx;
  logic       win_found;

  // Winner selection: descending scan with wrap; fixed priority is the scan starting at 3,
  // round-robin starts just below the previous winner so that winner is checked last.
  always_comb begin
    scan_base = rr_en_i ? (last_q - 2'd1) : 2'd3;
    scan_idx  = 2'd0;
    win_idx   = 2'd0;
    win_found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      scan_idx = scan_base - 2'(k);
      if (!win_found && req_i[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Next-state logic: grant from IDLE, then release on owner drop or hold-limit expiry.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    expired_d  = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (win_found) begin
          state_d    = GRANT;
          gnt_d      = 4'b0001 << win_idx;
          gnt_id_d   = win_idx;
          last_d     = win_idx;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        // Owner drop takes precedence over expiry, so a simultaneous drop is a normal release.
        if (!req_i[gnt_id_q]) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d   = IDLE;
          gnt_d     = 4'b0000;
          expired_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      gnt_q      <= 4'b0000;
      gnt_id_q   <= 2'd0;
      last_q     <= 2'd0;
      expired_q  <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      last_q     <= last_d;
      expired_q  <= expired_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_id_o  = gnt_id_q;
  assign gnt_vld_o = |gnt_q;
  assign expired_o = expired_q;

endmodule

// File: tb/tb_arb4_grant_ctrl.sv
// Bench for arb4_grant_ctrl: per-scenario stimulus tables, expectations queued at drive time.
// Each cycle the driven inputs and the outputs expected after the next edge are queued together.
// Outputs are sampled 1 time unit after the rising edge.
module tb_arb4_grant_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       rr_en_i = 1'b0;
  logic [3:0] req_i = 4'b0000;
  logic [3:0] gnt_o;
  logic [1:0] gnt_id_o;
  logic       gnt_vld_o;
  logic       expired_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       ex;
  } exp_t;

  exp_t sb_q[$];

  arb4_grant_ctrl #(.MAX_HOLD(8), .CNT_W(8)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rr_en_i   (rr_en_i),
    .req_i     (req_i),
    .gnt_o     (gnt_o),
    .gnt_id_o  (gnt_id_o),
    .gnt_vld_o (gnt_vld_o),
    .expired_o (expired_o)
  );

  always #5 clk_i = ~clk_i;

  // Table entry: inputs for one cycle plus outputs expected after the following edge.
  function automatic logic [12:0] ent(input logic rst, input logic rr, input logic [3:0] rq,
                                      input logic [3:0] g, input logic [1:0] id, input logic ex);
    return {rst, rr, rq, g, id, ex};
  endfunction

  // Drive one cycle of inputs, queue its expectation, advance to just after the edge.
  task automatic apply(input logic [12:0] v);
    exp_t e;
    rst_i   = v[12];
    rr_en_i = v[11];
    req_i   = v[10:7];
    e.gnt   = v[6:3];
    e.id    = v[2:1];
    e.ex    = v[0];
    sb_q.push_back(e);
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] tbl[$];
    exp_t e;
    tbl.push_back(ent(1, 0, 4'b1111, 4'b0000, 2'd0, 0));
    tbl.push_back(ent(1, 0, 4'b1111, 4'b0000, 2'd0, 0));
    tbl.push_back(ent(0, 0, 4'b1111, 4'b1000, 2'd3, 0));
    tbl.push_back(ent(0, 0, 4'b0000, 4'b0000, 2'd3, 0));
    tbl.push_back(ent(0, 0, 4'b0000, 4'b0000, 2'd3, 0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      e = sb_q.pop_front();
      checks++;
      if (gnt_o !== e.gnt) begin errors++; $display("FAIL reset gnt cyc %0d: got %b want %b", i, gnt_o, e.gnt); end
      checks++;
      if (gnt_id_o !== e.id) begin errors++; $display("FAIL reset gnt_id cyc %0d: got %0d want %0d", i, gnt_id_o, e.id); end
      checks++;
      if (gnt_vld_o !== (|e.gnt)) begin errors++; $display("FAIL reset gnt_vld cyc %0d: got %b want %b", i, gnt_vld_o, |e.gnt); end
      checks++;
      if (expired_o !== e.ex) begin errors++; $display("FAIL reset expired cyc %0d: got %b want %b", i, expired_o, e.ex); end
    end
  endtask

  task automatic test_fixed_priority();
    logic [12:0] tbl[$];
    exp_t e;
    tbl.push_back(ent(0, 0, 4'b0110, 4'b0100, 2'd2, 0));
    tbl.push_back(ent(0, 0, 4'b0110, 4'b0100, 2'd2, 0));
    tbl.push_back(ent(0, 0, 4'b1110, 4'b0100, 2'd2, 0)); // req[3] rises: no preemption
    tbl.push_back(ent(0, 0, 4'b0110, 4'b0100, 2'd2, 0));
    tbl.push_back(ent(0, 0, 4'b0010, 4'b0000, 2'd2, 0)); // owner drops
    tbl.push_back(ent(0, 0, 4'b0010, 4'b0010, 2'd1, 0));
    tbl.push_back(ent(0, 0, 4'b0000, 4'b0000, 2'd1, 0));
    tbl.push_back(ent(0, 0, 4'b0000, 4'b0000, 2'd1, 0));
    tbl.push_back(ent(0, 0, 4'b0011, 4'b0010, 2'd1, 0)); // fixed mode ignores last winner
    tbl.push_back(ent(0, 0, 4'b0000, 4'b0000, 2'd1, 0));
    tbl.push_back(ent(0, 0, 4'b0000, 4'b0000, 2'd1, 0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      e = sb_q.pop_front();
      checks++;
      if (gnt_o !== e.gnt) begin errors++; $display("FAIL fixed gnt cyc %0d: got %b want %b", i, gnt_o, e.gnt); end
      checks++;
      if (gnt_id_o !== e.id) begin errors++; $display("FAIL fixed gnt_id cyc %0d: got %0d want %0d", i, gnt_id_o, e.id); end
      checks++;
      if (gnt_vld_o !== (|e.gnt)) begin errors++; $display("FAIL fixed gnt_vld cyc %0d: got %b want %b", i, gnt_vld_o, |e.gnt); end
      checks++;
      if (expired_o !== e.ex) begin errors++; $display("FAIL fixed expired cyc %0d: got %b want %b", i, expired_o, e.ex); end
    end
  endtask

  task automatic test_round_robin();
    logic [12:0] tbl[$];
    exp_t e;
    tbl.push_back(ent(1, 1, 4'b0000, 4'b0000, 2'd0, 0)); // restart with last = 0
    tbl.push_back(ent(0, 1, 4'b1111, 4'b1000, 2'd3, 0));
    tbl.push_back(ent(0, 1, 4'b1111, 4'b1000, 2'd3, 0));
    tbl.push_back(ent(0, 1, 4'b0111, 4'b0000, 2'd3, 0));
    tbl.push_back(ent(0, 1, 4'b1111, 4'b0100, 2'd2, 0));
    tbl.push_back(ent(0, 1, 4'b1111, 4'b0100, 2'd2, 0));
    tbl.push_back(ent(0, 1, 4'b1011, 4'b0000, 2'd2, 0));
    tbl.push_back(ent(0, 1, 4'b1111, 4'b0010, 2'd1, 0));
    tbl.push_back(ent(0, 1, 4'b1111, 4'b0010, 2'd1, 0));
    tbl.push_back(ent(0, 1, 4'b1101, 4'b0000, 2'd1, 0));
    tbl.push_back(ent(0, 1, 4'b1111, 4'b0001, 2'd0, 0));
    tbl.push_back(ent(0, 1, 4'b1111, 4'b0001, 2'd0, 0));
    tbl.push_back(ent(0, 1, 4'b1110, 4'b0000, 2'd0, 0));
    tbl.push_back(ent(0, 1, 4'b1111, 4'b1000, 2'd3, 0));
    tbl.push_back(ent(0, 1, 4'b0000, 4'b0000, 2'd3, 0));
    tbl.push_back(ent(0, 1, 4'b0000, 4'b0000, 2'd3, 0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      e = sb_q.pop_front();
      checks++;
      if (gnt_o !== e.gnt) begin errors++; $display("FAIL rr gnt cyc %0d: got %b want %b", i, gnt_o, e.gnt); end
      checks++;
      if (gnt_id_o !== e.id) begin errors++; $display("FAIL rr gnt_id cyc %0d: got %0d want %0d", i, gnt_id_o, e.id); end
      checks++;
      if (gnt_vld_o !== (|e.gnt)) begin errors++; $display("FAIL rr gnt_vld cyc %0d: got %b want %b", i, gnt_vld_o, |e.gnt); end
      checks++;
      if (expired_o !== e.ex) begin errors++; $display("FAIL rr expired cyc %0d: got %b want %b", i, expired_o, e.ex); end
    end
  endtask

  task automatic test_hold_limit();
    logic [12:0] tbl[$];
    exp_t e;
    for (int k = 0; k < 8; k++) tbl.push_back(ent(0, 0, 4'b0001, 4'b0001, 2'd0, 0));
    tbl.push_back(ent(0, 0, 4'b0001, 4'b0000, 2'd0, 1)); // forced release
    tbl.push_back(ent(0, 0, 4'b0001, 4'b0001, 2'd0, 0)); // regrant after dead cycle
    tbl.push_back(ent(0, 0, 4'b0000, 4'b0000, 2'd0, 0));
    tbl.push_back(ent(0, 0, 4'b0000, 4'b0000, 2'd0, 0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      e = sb_q.pop_front();
      checks++;
      if (gnt_o !== e.gnt) begin errors++; $display("FAIL hold gnt cyc %0d: got %b want %b", i, gnt_o, e.gnt); end
      checks++;
      if (gnt_id_o !== e.id) begin errors++; $display("FAIL hold gnt_id cyc %0d: got %0d want %0d", i, gnt_id_o, e.id); end
      checks++;
      if (gnt_vld_o !== (|e.gnt)) begin errors++; $display("FAIL hold gnt_vld cyc %0d: got %b want %b", i, gnt_vld_o, |e.gnt); end
      checks++;
      if (expired_o !== e.ex) begin errors++; $display("FAIL hold expired cyc %0d: got %b want %b", i, expired_o, e.ex); end
    end
  endtask

  task automatic test_simultaneous();
    logic [12:0] tbl[$];
    exp_t e;
    for (int k = 0; k < 8; k++) tbl.push_back(ent(0, 0, 4'b0100, 4'b0100, 2'd2, 0));
    tbl.push_back(ent(0, 0, 4'b0000, 4'b0000, 2'd2, 0)); // drop at last hold cycle
    tbl.push_back(ent(0, 0, 4'b0000, 4'b0000, 2'd2, 0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      e = sb_q.pop_front();
      checks++;
      if (gnt_o !== e.gnt) begin errors++; $display("FAIL simul gnt cyc %0d: got %b want %b", i, gnt_o, e.gnt); end
      checks++;
      if (gnt_id_o !== e.id) begin errors++; $display("FAIL simul gnt_id cyc %0d: got %0d want %0d", i, gnt_id_o, e.id); end
      checks++;
      if (gnt_vld_o !== (|e.gnt)) begin errors++; $display("FAIL simul gnt_vld cyc %0d: got %b want %b", i, gnt_vld_o, |e.gnt); end
      checks++;
      if (expired_o !== e.ex) begin errors++; $display("FAIL simul expired cyc %0d: got %b want %b", i, expired_o, e.ex); end
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] tbl[$];
    exp_t e;
    for (int k = 0; k < 4; k++) tbl.push_back(ent(0, 0, 4'b1000, 4'b1000, 2'd3, 0));
    tbl.push_back(ent(1, 0, 4'b1000, 4'b0000, 2'd0, 0)); // reset at hold_cnt = 3
    tbl.push_back(ent(0, 0, 4'b0000, 4'b0000, 2'd0, 0));
    tbl.push_back(ent(0, 1, 4'b1001, 4'b1000, 2'd3, 0)); // last cleared: 3 wins over 0
    tbl.push_back(ent(0, 1, 4'b0000, 4'b0000, 2'd3, 0));
    tbl.push_back(ent(0, 1, 4'b0000, 4'b0000, 2'd3, 0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      e = sb_q.pop_front();
      checks++;
      if (gnt_o !== e.gnt) begin errors++; $display("FAIL rstmid gnt cyc %0d: got %b want %b", i, gnt_o, e.gnt); end
      checks++;
      if (gnt_id_o !== e.id) begin errors++; $display("FAIL rstmid gnt_id cyc %0d: got %0d want %0d", i, gnt_id_o, e.id); end
      checks++;
      if (gnt_vld_o !== (|e.gnt)) begin errors++; $display("FAIL rstmid gnt_vld cyc %0d: got %b want %b", i, gnt_vld_o, |e.gnt); end
      checks++;
      if (expired_o !== e.ex) begin errors++; $display("FAIL rstmid expired cyc %0d: got %b want %b", i, expired_o, e.ex); end
    end
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_hold_limit();
    test_simultaneous();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
